i2c_bus_filter: RTL and testbench



---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_glitch_filter.sv | 62 ++++++
 rtl/i2c_bus_filter.sv | 127 ++++++++++++
 tb/tb_i2c_bus_filter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C front end and the downstream slave engine.
package i2c_pkg;

    localparam int   FILT_LEN_DEF    = 4;
    localparam int   TIMEOUT_CYC_DEF = 100000;
    localparam logic IDLE_LVL        = 1'b1;

    // Cycles after reset release before a filtered line is guaranteed to
    // have converged from IDLE_LVL to the real pin level.
    function automatic int settle_cycles(input int filt_len);
        return filt_len + 4;
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line conditioner: 2-flop synchroniser, persistence filter, registered
// level with one-cycle rise/fall strobes.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic       filt_p2;
    logic [3:0] cnt_p2;

    // Stage p0/p1: synchroniser
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= i_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: level must persist FILT_LEN sync cycles before it is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filt_p2 <= IDLE_LVL;
            cnt_p2  <= 4'd0;
        end else if (sync_p1 == filt_p2) begin
            cnt_p2  <= 4'd0;
        end else if (cnt_p2 == CNT_LAST) begin
            filt_p2 <= sync_p1;
            cnt_p2  <= 4'd0;
        end else begin
            cnt_p2  <= cnt_p2 + 4'd1;
        end
    end

    // Stage p3: registered level and strobes change on the same edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_level <= IDLE_LVL;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_level <= filt_p2;
            o_rise  <= filt_p2 & ~o_level;
            o_fall  <= ~filt_p2 & o_level;
        end
    end

endmodule

// File: rtl/i2c_bus_filter.sv
// I2C bus front end: filtered SCL/SDA, edge strobes, START/STOP and busy.
// Optional SCL-low timeout is built only when I2C_BUS_TIMEOUT_EN is defined.
module i2c_bus_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_busy,
    output logic o_timeout
);

    localparam logic [4:0] SETTLE = 5'(settle_cycles(FILT_LEN));

    logic       sda_rise;
    logic       sda_fall;
    logic [4:0] settle_cnt;
    logic       armed;
    logic       scl_quiet;
    logic       start_det;
    logic       stop_det;
    logic       to_fire;
    logic       busy;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_scl),
        .o_level (o_scl),
        .o_rise  (o_scl_rise),
        .o_fall  (o_scl_fall)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (i_sda),
        .o_level (o_sda),
        .o_rise  (sda_rise),
        .o_fall  (sda_fall)
    );

    // Edges produced while the filters converge from the idle reset level are
    // not bus conditions, so START/STOP stay disarmed until that has passed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle_cnt <= 5'd0;
        end else if (!armed) begin
            settle_cnt <= settle_cnt + 5'd1;
        end
    end

    always_comb begin
        armed     = (settle_cnt == SETTLE);
        scl_quiet = o_scl & ~o_scl_rise & ~o_scl_fall;
        start_det = armed & scl_quiet & sda_fall;
        stop_det  = armed & scl_quiet & sda_rise;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy <= 1'b0;
        end else if (to_fire) begin
            busy <= 1'b0;
        end else if (start_det) begin
            busy <= 1'b1;
        end else if (stop_det) begin
            busy <= 1'b0;
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    localparam int                TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_hold;
    logic            timeout_q;

    // Fires on the TIMEOUT_CYC-th consecutive busy SCL-low cycle; the hold
    // flag blocks any further pulse until SCL is seen high again.
    assign to_fire = busy & ~o_scl & ~to_hold & (to_cnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt    <= '0;
            to_hold   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_fire;
            if (o_scl || !busy || to_fire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (o_scl) begin
                to_hold <= 1'b0;
            end else if (to_fire) begin
                to_hold <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_to_cfg;

    assign unused_to_cfg = (TIMEOUT_CYC > 0);
    assign to_fire       = 1'b0;
    assign o_timeout     = 1'b0;
`endif

    assign o_start = start_det;
    assign o_stop  = stop_det;
    assign o_busy  = busy;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Self-checking bench for i2c_bus_filter with a behavioural bus model.
module tb_i2c_bus_filter;

    localparam int F  = 4;
    localparam int TO = 50;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    logic i_scl = 1'b1;
    logic i_sda = 1'b1;
    logic o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy, o_timeout;

    int nchk = 0;
    int nfail = 0;

    i2c_bus_filter #(.FILT_LEN(F), .TIMEOUT_CYC(TO)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_scl      (o_scl),
        .o_sda      (o_sda),
        .o_scl_rise (o_scl_rise),
        .o_scl_fall (o_scl_fall),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a filtered line follows once the last F sampled pin
    // values (seen 2 sync + 1 output register later) all differ from it.
    logic [0:20] hs, hd;
    logic m_scl, m_sda, m_sr, m_sf, m_dr, m_df, m_start, m_stop, m_busy, m_to;
    logic dif_s, dif_d, fire;
    int   ncyc, lc;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs = '1; hd = '1;
            m_scl = 1'b1; m_sda = 1'b1;
            m_sr = 0; m_sf = 0; m_dr = 0; m_df = 0;
            m_start = 0; m_stop = 0; m_busy = 0; m_to = 0;
            ncyc = 0; lc = 0;
        end else begin
            fire = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
            if (m_busy && !m_scl) begin
                lc = lc + 1;
                if (lc == TO) begin
                    fire = 1'b1;
                    lc = 0;
                end
            end else begin
                lc = 0;
            end
`endif
            m_to = fire;
            if (fire) m_busy = 1'b0;
            else if (m_start) m_busy = 1'b1;
            else if (m_stop) m_busy = 1'b0;
            hs = {i_scl, hs[0:19]};
            hd = {i_sda, hd[0:19]};
            dif_s = 1'b1;
            dif_d = 1'b1;
            for (int j = 3; j <= F + 2; j++) begin
                if (hs[j] == m_scl) dif_s = 1'b0;
                if (hd[j] == m_sda) dif_d = 1'b0;
            end
            m_sr = dif_s & ~m_scl;
            m_sf = dif_s & m_scl;
            m_dr = dif_d & ~m_sda;
            m_df = dif_d & m_sda;
            if (dif_s) m_scl = ~m_scl;
            if (dif_d) m_sda = ~m_sda;
            if (ncyc < F + 4) ncyc = ncyc + 1;
            m_start = (ncyc >= F + 4) && m_df && m_scl && !dif_s;
            m_stop  = (ncyc >= F + 4) && m_dr && m_scl && !dif_s;
        end
    end

    wire [7:0] dut_v = {o_scl, o_sda, o_scl_rise, o_scl_fall, o_start, o_stop, o_busy, o_timeout};
    wire [7:0] exp_v = {m_scl, m_sda, m_sr, m_sf, m_start, m_stop, m_busy, m_to};

    task automatic clk1(input logic scl, input logic sda);
        i_scl = scl;
        i_sda = sda;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_scl = 1'b1;
        i_sda = 1'b1;
        #2 i_rst_n = 1'b0;
        #20;
        nchk++;
        if (dut_v !== 8'b1100_0000) begin
            nfail++;
            $display("FAIL reset_state: got %b expected %b", dut_v, 8'b1100_0000);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_latency();
        for (int k = 1; k <= 24; k++) begin
            clk1(1'b1, (k >= 10) ? 1'b0 : 1'b1);
            nchk++;
            if (dut_v !== exp_v) begin
                nfail++;
                $display("FAIL latency_model k=%0d: got %b expected %b", k, dut_v, exp_v);
            end
            if (k == 15) begin
                nchk++;
                if (o_sda !== 1'b1) begin
                    nfail++;
                    $display("FAIL latency_early: o_sda got %b expected 1 at cycle 15", o_sda);
                end
            end
            if (k == 16) begin
                nchk++;
                if ({o_sda, o_start} !== 2'b01) begin
                    nfail++;
                    $display("FAIL latency_edge: {o_sda,o_start} got %b expected 01 at cycle 16", {o_sda, o_start});
                end
            end
            if (k == 17) begin
                nchk++;
                if (o_busy !== 1'b1) begin
                    nfail++;
                    $display("FAIL busy_set: got %b expected 1", o_busy);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int nf, nr;
        for (int p = 3; p <= 4; p++) begin
            nf = 0;
            nr = 0;
            for (int k = 0; k < 16; k++) begin
                clk1((k < p) ? 1'b0 : 1'b1, 1'b0);
                nchk++;
                if (dut_v !== exp_v) begin
                    nfail++;
                    $display("FAIL glitch_model p=%0d k=%0d: got %b expected %b", p, k, dut_v, exp_v);
                end
                nf += int'(o_scl_fall);
                nr += int'(o_scl_rise);
            end
            nchk++;
            if (nf != p - 3 || nr != p - 3) begin
                nfail++;
                $display("FAIL glitch_count p=%0d: falls %0d rises %0d expected %0d each", p, nf, nr, p - 3);
            end
        end
    endtask

    task automatic test_transaction();
        int starts, stops, rises;
        logic cur, d;
        stops = 0;
        for (int k = 0; k < 12; k++) begin
            clk1(1'b1, 1'b1);
            nchk++;
            if (dut_v !== exp_v) begin
                nfail++;
                $display("FAIL idle_model k=%0d: got %b expected %b", k, dut_v, exp_v);
            end
        end
        starts = 0;
        for (int k = 0; k < 12; k++) begin
            clk1(1'b1, 1'b0);
            starts += int'(o_start);
        end
        nchk++;
        if (starts != 1 || o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL start_basic: starts %0d busy %b expected 1 and 1", starts, o_busy);
        end
        cur = 1'b0;
        starts = 0;
        rises = 0;
        for (int b = 0; b < 8; b++) begin
            d = (b == 7) ? 1'b0 : 1'(($urandom_range(0, 1)));
            for (int k = 0; k < 16; k++) begin
                clk1((k < 8) ? 1'b0 : 1'b1, (k < 4) ? cur : d);
                nchk++;
                if (dut_v !== exp_v) begin
                    nfail++;
                    $display("FAIL xfer_model b=%0d k=%0d: got %b expected %b", b, k, dut_v, exp_v);
                end
                starts += int'(o_start);
                stops  += int'(o_stop);
                rises  += int'(o_scl_rise);
            end
            cur = d;
        end
        nchk++;
        if (rises != 8 || starts != 0 || stops != 0) begin
            nfail++;
            $display("FAIL xfer_counts: rises %0d starts %0d stops %0d expected 8 0 0", rises, starts, stops);
        end
        stops = 0;
        for (int k = 0; k < 12; k++) begin
            clk1(1'b1, 1'b1);
            stops += int'(o_stop);
        end
        nchk++;
        if (stops != 1 || o_busy !== 1'b0) begin
            nfail++;
            $display("FAIL stop_basic: stops %0d busy %b expected 1 and 0", stops, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] lv [8];
        int st_rep, ev_sim, sp_end;
        lv = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11};
        st_rep = 0;
        ev_sim = 0;
        sp_end = 0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 12; k++) begin
                clk1(lv[s][1], lv[s][0]);
                nchk++;
                if (dut_v !== exp_v) begin
                    nfail++;
                    $display("FAIL b2b_model s=%0d k=%0d: got %b expected %b", s, k, dut_v, exp_v);
                end
                if (s >= 1 && s <= 6 && o_busy !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b_busy s=%0d k=%0d: got %b expected 1", s, k, o_busy);
                end
                if (s == 4) st_rep += int'(o_start);
                if (s == 5 || s == 6) ev_sim += int'(o_start) + int'(o_stop);
                if (s == 7) sp_end += int'(o_stop);
            end
        end
        nchk++;
        if (st_rep != 1 || ev_sim != 0 || sp_end != 1) begin
            nfail++;
            $display("FAIL b2b_counts: rep_start %0d simul %0d stop %0d expected 1 0 1", st_rep, ev_sim, sp_end);
        end
    endtask

    task automatic test_reset_mid();
        int starts, stops, busy_hi;
        for (int k = 0; k < 12; k++) clk1(1'b1, 1'b0);
        nchk++;
        if (o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL rmid_pre: busy got %b expected 1", o_busy);
        end
        #2 i_rst_n = 1'b0;
        #1;
        nchk++;
        if (o_busy !== 1'b0 || dut_v !== exp_v) begin
            nfail++;
            $display("FAIL rmid_async: got %b expected %b", dut_v, exp_v);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            clk1(1'b1, 1'b0);
            nchk++;
            if (dut_v !== exp_v) begin
                nfail++;
                $display("FAIL rmid_model k=%0d: got %b expected %b", k, dut_v, exp_v);
            end
            starts += int'(o_start);
        end
        stops = 0;
        busy_hi = 0;
        for (int k = 0; k < 12; k++) begin
            clk1(1'b1, 1'b1);
            stops += int'(o_stop);
            busy_hi += int'(o_busy);
        end
        nchk++;
        if (starts != 0 || stops != 1 || busy_hi != 0) begin
            nfail++;
            $display("FAIL rmid_no_start: starts %0d stops %0d busy_cycles %0d expected 0 1 0", starts, stops, busy_hi);
        end
        starts = 0;
        for (int k = 0; k < 12; k++) begin
            clk1(1'b1, 1'b0);
            starts += int'(o_start);
        end
        nchk++;
        if (starts != 1) begin
            nfail++;
            $display("FAIL rmid_fresh_start: starts %0d expected 1", starts);
        end
    endtask

    task automatic test_timeout();
        int tos, at;
        tos = 0;
        at = -1;
        for (int k = 0; k < 70; k++) begin
            clk1(1'b0, 1'b0);
            nchk++;
            if (dut_v !== exp_v) begin
                nfail++;
                $display("FAIL timeout_model k=%0d: got %b expected %b", k, dut_v, exp_v);
            end
            if (o_timeout === 1'b1) begin
                tos++;
                at = k;
            end
        end
        nchk++;
`ifdef I2C_BUS_TIMEOUT_EN
        if (tos != 1 || at != 56 || o_busy !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_pulse: pulses %0d at %0d busy %b expected 1 at 56 busy 0", tos, at, o_busy);
        end
`else
        if (tos != 0 || o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL timeout_absent: pulses %0d busy %b expected 0 busy 1", tos, o_busy);
        end
`endif
        for (int k = 0; k < 24; k++) begin
            clk1(1'b1, (k < 12) ? 1'b0 : 1'b1);
            nchk++;
            if (dut_v !== exp_v) begin
                nfail++;
                $display("FAIL timeout_exit k=%0d: got %b expected %b", k, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic s, d;
        int n;
        for (int i = 0; i < 80; i++) begin
            s = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                clk1(s, d);
                nchk++;
                if (dut_v !== exp_v) begin
                    nfail++;
                    $display("FAIL random_model seg=%0d k=%0d: got %b expected %b", i, k, dut_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_transaction();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
